// File: rtl/proyecto1_pkg.sv
// Shared definitions for the Proyecto1 phase sequencer: phase encodings and default widths.
package proyecto1_pkg;

   localparam int unsigned CW_DEF = 6;

   typedef enum logic [2:0] {
      PH_IDLE = 3'b000,
      PH_PH1  = 3'b001,
      PH_PH2  = 3'b010,
      PH_PH3  = 3'b011,
      PH_DONE = 3'b100
   } phase_e;

endpackage

// File: rtl/seq_down_cnt.sv
// Loadable down-counter that saturates at zero; load takes priority over enable.
module seq_down_cnt
   import proyecto1_pkg::*;
#(
   parameter int unsigned CW = CW_DEF
) (
   input  logic          clck,
   input  logic          rst,
   input  logic          ld,
   input  logic [CW-1:0] ld_val,
   input  logic          en,
   output logic [CW-1:0] cnt,
   output logic          zero
);

   logic [CW-1:0] cnt_d, cnt_q;

   assign zero = (cnt_q == '0);
   assign cnt  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (ld) begin
         cnt_d = ld_val;
      end else if (en && !zero) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clck) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/proyecto1_timer_seq.sv
// Three-phase timed sequencer: PH1 -> PH2 -> PH3 -> DONE with programmable lengths,
// emitting a registered one-cycle T pulse at each phase exit.
module proyecto1_timer_seq
   import proyecto1_pkg::*;
#(
   parameter int unsigned CW      = CW_DEF,
   parameter int unsigned PH1_LEN = 10,
   parameter int unsigned PH2_LEN = 20,
   parameter int unsigned PH3_LEN = 8
) (
   input  logic          clck,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic          hold,
   input  logic          len_ld,
   input  logic [1:0]    len_sel,
   input  logic [CW-1:0] len_val,
   output logic          T,
   output logic [2:0]    phase,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] cnt
);

   phase_e        phase_d, phase_q;
   logic          t_d, t_q;
   logic          busy_d, busy_q;
   logic          done_d, done_q;
   logic [CW-1:0] len1_d, len1_q, len2_d, len2_q, len3_d, len3_q;
   logic          cnt_ld, cnt_en, cnt_zero;
   logic [CW-1:0] cnt_ldv;

   // A stored length of 0 behaves as a 1-cycle phase.
   function automatic logic [CW-1:0] load_of(input logic [CW-1:0] len);
      return (len == '0) ? '0 : len - 1'b1;
   endfunction

   seq_down_cnt #(
      .CW (CW)
   ) u_cnt (
      .clck   (clck),
      .rst    (rst),
      .ld     (cnt_ld),
      .ld_val (cnt_ldv),
      .en     (cnt_en),
      .cnt    (cnt),
      .zero   (cnt_zero)
   );

   always_comb begin
      len1_d = len1_q;
      len2_d = len2_q;
      len3_d = len3_q;
      if (len_ld) begin
         case (len_sel)
            2'd0:    len1_d = len_val;
            2'd1:    len2_d = len_val;
            2'd2:    len3_d = len_val;
            default: ;
         endcase
      end
   end

   always_comb begin
      phase_d = phase_q;
      t_d     = 1'b0;
      cnt_ld  = 1'b0;
      cnt_ldv = '0;
      cnt_en  = 1'b0;
      if (abort) begin
         phase_d = PH_IDLE;
         cnt_ld  = 1'b1;
      end else begin
         case (phase_q)
            PH_IDLE: begin
               if (start) begin
                  phase_d = PH_PH1;
                  cnt_ld  = 1'b1;
                  cnt_ldv = load_of(len1_q);
               end
            end
            PH_PH1, PH_PH2, PH_PH3: begin
               if (!hold) begin
                  if (!cnt_zero) begin
                     cnt_en = 1'b1;
                  end else begin
                     t_d    = 1'b1;
                     cnt_ld = 1'b1;
                     if (phase_q == PH_PH1) begin
                        phase_d = PH_PH2;
                        cnt_ldv = load_of(len2_q);
                     end else if (phase_q == PH_PH2) begin
                        phase_d = PH_PH3;
                        cnt_ldv = load_of(len3_q);
                     end else begin
                        phase_d = PH_DONE;
                     end
                  end
               end
            end
            PH_DONE: begin
               phase_d = PH_IDLE;
               cnt_ld  = 1'b1;
            end
            default: begin
               phase_d = PH_IDLE;
               cnt_ld  = 1'b1;
            end
         endcase
      end
      busy_d = (phase_d == PH_PH1) || (phase_d == PH_PH2) || (phase_d == PH_PH3);
      done_d = (phase_d == PH_DONE);
   end

   always_ff @(posedge clck) begin
      if (!rst) begin
         phase_q <= PH_IDLE;
         t_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         len1_q  <= CW'(PH1_LEN);
         len2_q  <= CW'(PH2_LEN);
         len3_q  <= CW'(PH3_LEN);
      end else begin
         phase_q <= phase_d;
         t_q     <= t_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         len1_q  <= len1_d;
         len2_q  <= len2_d;
         len3_q  <= len3_d;
      end
   end

   assign T     = t_q;
   assign phase = phase_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_proyecto1_timer_seq.sv
// Scoreboard bench for proyecto1_timer_seq: stimulus queues expected T/done events and
// state snapshots by edge number; a negedge monitor pops and compares them.
module tb_proyecto1_timer_seq;

   logic       clck = 1'b0;
   logic       rst, start, abort, hold, len_ld;
   logic [1:0] len_sel;
   logic [5:0] len_val;
   logic       T, busy, done;
   logic [2:0] phase;
   logic [5:0] cnt;

   int cyc   = 0;
   int total = 0;
   int bad   = 0;

   typedef struct {
      int         c;
      logic [2:0] ph;
      logic [5:0] cn;
      logic       t;
      logic       bz;
      logic       dn;
      string      nm;
   } snap_t;

   typedef struct {
      int    c;
      string nm;
   } ev_t;

   snap_t snap_q[$];
   ev_t   t_q[$];
   ev_t   d_q[$];

   proyecto1_timer_seq dut (
      .clck    (clck),
      .rst     (rst),
      .start   (start),
      .abort   (abort),
      .hold    (hold),
      .len_ld  (len_ld),
      .len_sel (len_sel),
      .len_val (len_val),
      .T       (T),
      .phase   (phase),
      .busy    (busy),
      .done    (done),
      .cnt     (cnt)
   );

   always #5 clck = ~clck;

   always @(posedge clck) cyc <= cyc + 1;

   task automatic push_snap(input int c, input logic [2:0] ph, input logic [5:0] cn,
                            input logic t, input logic bz, input logic dn, input string nm);
      snap_t s;
      int    i;
      s.c = c; s.ph = ph; s.cn = cn; s.t = t; s.bz = bz; s.dn = dn; s.nm = nm;
      i = 0;
      while (i < snap_q.size() && snap_q[i].c <= c) i++;
      snap_q.insert(i, s);
   endtask

   task automatic push_t(input int c, input string nm);
      ev_t e;
      int  i;
      e.c = c; e.nm = nm;
      i = 0;
      while (i < t_q.size() && t_q[i].c <= c) i++;
      t_q.insert(i, e);
   endtask

   task automatic push_d(input int c, input string nm);
      ev_t e;
      int  i;
      e.c = c; e.nm = nm;
      i = 0;
      while (i < d_q.size() && d_q[i].c <= c) i++;
      d_q.insert(i, e);
   endtask

   // Expected events for an undisturbed run whose start is sampled at edge e0.
   task automatic push_run(input int e0, input int l1, input int l2, input int l3,
                           input string nm);
      int a, b, c;
      a = (l1 == 0) ? 1 : l1;
      b = (l2 == 0) ? 1 : l2;
      c = (l3 == 0) ? 1 : l3;
      push_t(e0 + a, {nm, " T1"});
      push_t(e0 + a + b, {nm, " T2"});
      push_t(e0 + a + b + c, {nm, " T3"});
      push_d(e0 + a + b + c, {nm, " done"});
      push_snap(e0 + a + b + c, 3'b100, 6'd0, 1'b1, 1'b0, 1'b1, {nm, " in_done"});
      push_snap(e0 + a + b + c + 1, 3'b000, 6'd0, 1'b0, 1'b0, 1'b0, {nm, " back_idle"});
   endtask

   task automatic step();
      @(posedge clck);
      #1;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) step();
   endtask

   task automatic load_len(input logic [1:0] sel, input logic [5:0] val);
      len_ld = 1'b1; len_sel = sel; len_val = val;
      step();
      len_ld = 1'b0;
   endtask

   always @(negedge clck) begin
      snap_t s;
      ev_t   e;
      while (snap_q.size() > 0 && snap_q[0].c < cyc) begin
         s = snap_q.pop_front();
         total++; bad++;
         $display("FAIL %s: snapshot for edge %0d missed (now %0d)", s.nm, s.c, cyc);
      end
      if (snap_q.size() > 0 && snap_q[0].c == cyc) begin
         s = snap_q.pop_front();
         total++;
         if ({phase, cnt, T, busy, done} !== {s.ph, s.cn, s.t, s.bz, s.dn}) begin
            bad++;
            $display("FAIL %s @%0d: got ph=%b cnt=%0d T=%b busy=%b done=%b want ph=%b cnt=%0d T=%b busy=%b done=%b",
                     s.nm, cyc, phase, cnt, T, busy, done, s.ph, s.cn, s.t, s.bz, s.dn);
         end
      end
      if (T === 1'b1) begin
         total++;
         if (t_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_T: got T=1 at edge %0d, want none", cyc);
         end else begin
            e = t_q.pop_front();
            if (e.c != cyc) begin
               bad++;
               $display("FAIL %s: got T at edge %0d, want edge %0d", e.nm, cyc, e.c);
            end
         end
      end
      if (done === 1'b1) begin
         total++;
         if (d_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done: got done=1 at edge %0d, want none", cyc);
         end else begin
            e = d_q.pop_front();
            if (e.c != cyc) begin
               bad++;
               $display("FAIL %s: got done at edge %0d, want edge %0d", e.nm, cyc, e.c);
            end
         end
      end
   end

   initial begin
      int e0;
      rst = 1'b0; start = 1'b1; abort = 1'b0; hold = 1'b0;
      len_ld = 1'b0; len_sel = 2'd0; len_val = 6'd0;

      // 1: reset dominates start, then reset lengths 10/20/8
      push_snap(1, 3'b000, 6'd0, 1'b0, 1'b0, 1'b0, "rst_e1");
      push_snap(2, 3'b000, 6'd0, 1'b0, 1'b0, 1'b0, "rst_e2");
      step(); step();
      rst = 1'b1;
      e0 = cyc + 1;
      push_run(e0, 10, 20, 8, "deflen");
      push_snap(e0 + 9, 3'b001, 6'd0, 1'b0, 1'b1, 1'b0, "deflen ph1_last");
      push_snap(e0 + 10, 3'b010, 6'd19, 1'b1, 1'b1, 1'b0, "deflen ph2_first");
      step();
      start = 1'b0;
      wait_to(e0 + 40);

      // 2: normal run 3/2/4
      load_len(2'd0, 6'd3);
      load_len(2'd1, 6'd2);
      load_len(2'd2, 6'd4);
      start = 1'b1;
      e0 = cyc + 1;
      push_run(e0, 3, 2, 4, "run324");
      push_snap(e0, 3'b001, 6'd2, 1'b0, 1'b1, 1'b0, "run324 ph1_first");
      push_snap(e0 + 4, 3'b010, 6'd0, 1'b0, 1'b1, 1'b0, "run324 ph2_last");
      push_snap(e0 + 8, 3'b011, 6'd0, 1'b0, 1'b1, 1'b0, "run324 ph3_last");
      step();
      start = 1'b0;
      wait_to(e0 + 12);

      // 3: hold for 4 edges during PH1 with cnt=1; hold in IDLE beforehand is harmless
      hold = 1'b1;
      step();
      start = 1'b1;
      hold = 1'b0;
      e0 = cyc + 1;
      push_run(e0 + 4, 3, 2, 4, "hold");
      for (int k = 2; k <= 5; k++)
         push_snap(e0 + k, 3'b001, 6'd1, 1'b0, 1'b1, 1'b0, "hold frozen");
      push_snap(e0 + 6, 3'b001, 6'd0, 1'b0, 1'b1, 1'b0, "hold resume");
      step();
      start = 1'b0;
      step();
      hold = 1'b1;
      repeat (4) step();
      hold = 1'b0;
      wait_to(e0 + 16);

      // 4: abort in PH2 with cnt=5, then rerun with stored len1
      load_len(2'd1, 6'd10);
      start = 1'b1;
      e0 = cyc + 1;
      push_t(e0 + 3, "abort T1");
      push_snap(e0 + 7, 3'b010, 6'd5, 1'b0, 1'b1, 1'b0, "abort before");
      push_snap(e0 + 8, 3'b000, 6'd0, 1'b0, 1'b0, 1'b0, "abort after");
      step();
      start = 1'b0;
      wait_to(e0 + 7);
      abort = 1'b1;
      step();
      abort = 1'b0;
      repeat (3) step();
      start = 1'b1;
      e0 = cyc + 1;
      push_run(e0, 3, 10, 4, "postabort");
      push_snap(e0 + 2, 3'b001, 6'd0, 1'b0, 1'b1, 1'b0, "postabort ph1_last");
      step();
      start = 1'b0;
      wait_to(e0 + 19);

      // 5: start while busy ignored; len2 rewrite mid-PH2 only affects the next run
      start = 1'b1;
      e0 = cyc + 1;
      push_run(e0, 3, 10, 4, "busy");
      push_snap(e0 + 4, 3'b010, 6'd8, 1'b0, 1'b1, 1'b0, "busy pre");
      push_snap(e0 + 5, 3'b010, 6'd7, 1'b0, 1'b1, 1'b0, "busy start_ign");
      step();
      start = 1'b0;
      wait_to(e0 + 4);
      start = 1'b1; len_ld = 1'b1; len_sel = 2'd1; len_val = 6'd1;
      step();
      start = 1'b0; len_ld = 1'b0;
      wait_to(e0 + 19);
      start = 1'b1;
      e0 = cyc + 1;
      push_run(e0, 3, 1, 4, "newlen2");
      step();
      start = 1'b0;
      wait_to(e0 + 10);

      // 6: all lengths zero -> 1-cycle phases
      load_len(2'd0, 6'd0);
      load_len(2'd1, 6'd0);
      load_len(2'd2, 6'd0);
      start = 1'b1;
      e0 = cyc + 1;
      push_run(e0, 0, 0, 0, "zero");
      push_snap(e0 + 1, 3'b010, 6'd0, 1'b1, 1'b1, 1'b0, "zero ph2");
      step();
      start = 1'b0;
      wait_to(e0 + 8);

      foreach (snap_q[i]) begin
         total++; bad++;
         $display("FAIL %s: snapshot for edge %0d never checked", snap_q[i].nm, snap_q[i].c);
      end
      foreach (t_q[i]) begin
         total++; bad++;
         $display("FAIL %s: got no T pulse, want one at edge %0d", t_q[i].nm, t_q[i].c);
      end
      foreach (d_q[i]) begin
         total++; bad++;
         $display("FAIL %s: got no done pulse, want one at edge %0d", d_q[i].nm, d_q[i].c);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
